row_window_loader: RTL

Upstream feeder for the row compressor stage. It accepts a stream of single words over a valid/ready handshake and packs them into rows of a runtime-selectable length, up to MAX_R_SIZE words. Unused lanes are zero-padded. Completed rows are presented as one WORD_WIDTH*MAX_R_SIZE vector with valid/ready, in the form the compressor consumes directly. Buffering is two-deep (assembly row plus output row), so the block sustains one word per cycle while the downstream side stalls briefly.

---
 rtl/row_window_loader.sv | 133 +++++++++++++
 1 files changed

// File: rtl/row_window_loader.sv
// row_window_loader: packs a valid/ready word stream into zero-padded rows of
// runtime length (r_len_m1_i + 1 words), behind a two-deep row buffer
// (assembly row plus output row).
// Optional build macro ROW_WINDOW_LOADER_ZERO_DROP_EN: rows whose real words
// are all zero are discarded at close instead of being emitted.
module row_window_loader #(
    parameter int WORD_WIDTH   = 8,
    parameter int MAX_R_SIZE   = 4,
    parameter int R_DIST_WIDTH = 2
) (
    input  logic                             clk_i,
    input  logic                             reset_n_i,
    input  logic [R_DIST_WIDTH-1:0]          r_len_m1_i,
    input  logic                             flush_i,
    input  logic                             s_valid_i,
    output logic                             s_ready_o,
    input  logic [WORD_WIDTH-1:0]            s_data_i,
    output logic                             m_valid_o,
    input  logic                             m_ready_i,
    output logic [WORD_WIDTH*MAX_R_SIZE-1:0] m_data_o,
    output logic [R_DIST_WIDTH:0]            m_count_o
);
    typedef logic [MAX_R_SIZE-1:0][WORD_WIDTH-1:0] row_t;

    // asm_cnt_q is one bit wider than a lane index so that a held (full)
    // row can keep its real word count, which may equal MAX_R_SIZE.
    row_t                    asm_data_q, asm_data_d;
    logic [R_DIST_WIDTH:0]   asm_cnt_q, asm_cnt_d;
    logic [R_DIST_WIDTH-1:0] asm_len_q, asm_len_d;
    logic                    asm_full_q, asm_full_d;
    row_t                    m_data_q, m_data_d;
    logic [R_DIST_WIDTH:0]   m_count_q, m_count_d;
    logic                    m_valid_q, m_valid_d;

    logic                    acc, close, slot_free, drop;
    logic [R_DIST_WIDTH-1:0] lane, len_eff;
    logic [R_DIST_WIDTH:0]   merged_cnt;
    row_t                    merged;

    assign s_ready_o = !asm_full_q;
    assign m_valid_o = m_valid_q;
    assign m_data_o  = m_data_q;
    assign m_count_o = m_count_q;

    assign acc        = s_valid_i && !asm_full_q;
    assign lane       = asm_cnt_q[R_DIST_WIDTH-1:0];
    // Row length is latched with the first word; later changes are ignored.
    assign len_eff    = (asm_cnt_q == '0) ? r_len_m1_i : asm_len_q;
    assign merged_cnt = asm_cnt_q + {{R_DIST_WIDTH{1'b0}}, acc};
    assign slot_free  = !m_valid_q || m_ready_i;
    assign close      = !asm_full_q &&
                        ((acc && lane == len_eff) ||
                         (flush_i && (asm_cnt_q != '0 || acc)));

    // Per-lane merge of the incoming word into the assembly row.
    for (genvar k = 0; k < MAX_R_SIZE; k++) begin : g_lane
        assign merged[k] = (acc && lane == R_DIST_WIDTH'(k)) ? s_data_i
                                                              : asm_data_q[k];
    end

`ifdef ROW_WINDOW_LOADER_ZERO_DROP_EN
    // Pad lanes are zero, so an all-zero vector means all real words are zero.
    assign drop = close && (merged == '0);
`else
    assign drop = 1'b0;
`endif

    // Next-state: assembly merge/close and output slot load/drain.
    always_comb begin
        asm_data_d = asm_data_q;
        asm_cnt_d  = asm_cnt_q;
        asm_len_d  = asm_len_q;
        asm_full_d = asm_full_q;
        m_data_d   = m_data_q;
        m_count_d  = m_count_q;
        m_valid_d  = m_valid_q;

        // Output transfer empties the slot unless something reloads it below.
        if (m_valid_q && m_ready_i) m_valid_d = 1'b0;

        if (asm_full_q) begin
            if (slot_free) begin
                m_data_d   = asm_data_q;
                m_count_d  = asm_cnt_q;
                m_valid_d  = 1'b1;
                asm_data_d = '0;
                asm_cnt_d  = '0;
                asm_full_d = 1'b0;
            end
        end else begin
            if (acc) begin
                asm_data_d = merged;
                asm_cnt_d  = merged_cnt;
                if (asm_cnt_q == '0) asm_len_d = r_len_m1_i;
            end
            if (close) begin
                if (drop) begin
                    asm_data_d = '0;
                    asm_cnt_d  = '0;
                end else if (slot_free) begin
                    m_data_d   = merged;
                    m_count_d  = merged_cnt;
                    m_valid_d  = 1'b1;
                    asm_data_d = '0;
                    asm_cnt_d  = '0;
                end else begin
                    asm_full_d = 1'b1;
                end
            end
        end
    end

    // State registers; reset discards both partial and pending rows.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            asm_data_q <= '0;
            asm_cnt_q  <= '0;
            asm_len_q  <= '0;
            asm_full_q <= 1'b0;
            m_data_q   <= '0;
            m_count_q  <= '0;
            m_valid_q  <= 1'b0;
        end else begin
            asm_data_q <= asm_data_d;
            asm_cnt_q  <= asm_cnt_d;
            asm_len_q  <= asm_len_d;
            asm_full_q <= asm_full_d;
            m_data_q   <= m_data_d;
            m_count_q  <= m_count_d;
            m_valid_q  <= m_valid_d;
        end
    end
endmodule
